// File: rtl/axi_stream_master.sv
// Pixel FIFO feeding an AXI-Stream master that frames beats into lines and frames.
// tuser marks the first beat of a frame, tlast the last beat of each line.
module axi_stream_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pixel_data,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = $clog2(FRAME_WIDTH);
    localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_frame_done;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_last_beat;

    assign w_full        = (r_count == CNT_FULL);
    assign w_empty       = (r_count == {CNT_W{1'b0}});
    assign w_push        = pixel_valid && !w_full;
    assign w_pop         = m_axis_tvalid && m_axis_tready;
    assign w_last_beat   = w_pop && (r_col == COL_LAST) && (r_row == ROW_LAST);

    // tdata is forced to zero whenever no beat is offered so stale FIFO
    // contents never leak onto the bus (and reset shows a clean zero).
    assign pixel_ready   = !w_full;
    assign m_axis_tvalid = (r_state == S_ACTIVE) && !w_empty;
    assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : {DATA_WIDTH{1'b0}};
    assign m_axis_tuser  = m_axis_tvalid && (r_col == {COL_W{1'b0}}) && (r_row == {ROW_W{1'b0}});
    assign m_axis_tlast  = m_axis_tvalid && (r_col == COL_LAST);
    assign busy          = (r_state == S_ACTIVE);
    assign frame_done    = r_frame_done;

    // FIFO storage: written on accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pixel_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM, column/row position and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_col        <= {COL_W{1'b0}};
            r_row        <= {ROW_W{1'b0}};
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_beat;
            case (r_state)
                S_IDLE:   r_state <= start ? S_ACTIVE : S_IDLE;
                S_ACTIVE: r_state <= w_last_beat ? S_IDLE : S_ACTIVE;
                default:  r_state <= S_IDLE;
            endcase
            if (w_pop) begin
                if (r_col == COL_LAST) begin
                    r_col <= {COL_W{1'b0}};
                    r_row <= (r_row == ROW_LAST) ? {ROW_W{1'b0}} : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/axi_stream_master.md
AXI_STREAM_MASTER -- requirements
Module: axi_stream_master

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the pixel/stream data width in bits.
REQ-002 The module SHALL have parameter FRAME_WIDTH, default 640, meaning pixels per line (>=2).
REQ-003 The module SHALL have parameter FRAME_HEIGHT, default 480, meaning lines per frame (>=1).
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries (power of 2, >=2).
REQ-005 Ports SHALL be, in order:
- clk  input  1  the single clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  single-cycle pulse that begins one frame
- pixel_data  input  DATA_WIDTH  pixel to enqueue
- pixel_valid  input  1  pixel_data is valid this cycle
- pixel_ready  output  1  FIFO can accept a pixel
- m_axis_tdata  output  DATA_WIDTH  stream data
- m_axis_tvalid  output  1  stream beat valid
- m_axis_tready  input  1  downstream slave accepts the beat
- m_axis_tlast  output  1  last pixel of a line
- m_axis_tuser  output  1  first pixel of a frame (start-of-frame)
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the final beat of a frame

Function
REQ-006 A pixel SHALL be pushed on any rising edge where pixel_valid && pixel_ready.
REQ-007 pixel_ready SHALL equal !full, computed from the registered FIFO count only; a push SHALL NOT be accepted when full, even if a pop occurs in the same cycle.
REQ-008 A stream beat SHALL be transferred (FIFO pop) on any rising edge where m_axis_tvalid && m_axis_tready.
REQ-009 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-010 The FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on start; ACTIVE->IDLE on the handshake of beat (col=FRAME_WIDTH-1, row=FRAME_HEIGHT-1).
REQ-011 start SHALL be ignored while ACTIVE.
REQ-012 In IDLE, m_axis_tvalid SHALL be 0; the FIFO SHALL still accept pixels.
REQ-013 In ACTIVE, m_axis_tvalid SHALL be 1 whenever the FIFO is non-empty, with m_axis_tdata equal to the FIFO head.
REQ-014 Latency: a pixel pushed at edge N into an empty FIFO while ACTIVE SHALL appear with m_axis_tvalid=1 in the cycle following edge N.
REQ-015 Once m_axis_tvalid is 1, it and tdata/tlast/tuser SHALL remain stable until the handshake completes.
REQ-016 The column counter (width ceil(log2(FRAME_WIDTH))) SHALL increment on each handshake and wrap to 0 after FRAME_WIDTH-1; the row counter SHALL increment on each column wrap and wrap to 0 after FRAME_HEIGHT-1.
REQ-017 m_axis_tuser SHALL be 1 exactly when m_axis_tvalid && col==0 && row==0.
REQ-018 m_axis_tlast SHALL be 1 exactly when m_axis_tvalid && col==FRAME_WIDTH-1.
REQ-019 Counters SHALL change only on handshakes; back-pressure (tready=0) SHALL hold them.
REQ-020 frame_done SHALL be a registered pulse, 1 in the cycle after the final handshake of a frame, and 0 otherwise.
REQ-021 busy SHALL be 1 exactly when the state is ACTIVE.

Reset
REQ-022 While rst=1 at a rising edge: state=IDLE, FIFO emptied, pointers/count=0, col=row=0.
REQ-023 Outputs after reset SHALL be m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, busy=0, frame_done=0, pixel_ready=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame, discard buffered pixels, and emit no frame_done.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2, FIFO_DEPTH=4, DATA_WIDTH=32)
REQ-025 Reset: hold rst 2 cycles -> all outputs at REQ-023 values; pixel_ready=1.
REQ-026 Full frame: start, then push 8 pixels 0x0..0x7 with tready=1 -> beats 0..7 in order; tuser only on 0x0; tlast on 0x3 and 0x7; frame_done pulse 1 cycle after beat 0x7; busy=0 afterwards.
REQ-027 Back-pressure: tready=0 with 0xA5A5A5A5 at the head for 5 cycles -> tvalid=1 and tdata held; counters unchanged; after 4 pushes pixel_ready=0 and a 5th push is rejected.
REQ-028 Full FIFO with simultaneous pop and push -> push rejected, count drops to 3, pixel_ready returns to 1 the next cycle.
REQ-029 Start ignored: a second start pulse during a frame -> no counter reset; exactly one frame_done per frame.
REQ-030 Mid-frame reset after beat 0x5 -> tvalid=0 the next cycle; a new start plus pushes 0xDEADBEEF.. -> first beat carries tuser=1.
